// File: rtl/signmag_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready handshake.
// Define SIGNMAG_SAT_EN to saturate the magnitude on effective-add carry.
module signmag_addsub_pipe #(
    parameter int W     = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             sign_a,
    input  logic [W-1:0]     mag_a,
    input  logic             sign_b,
    input  logic [W-1:0]     mag_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [W-1:0]     res_mag,
    output logic             o_carry,
    output logic             shift_flag,
    output logic             res_zero,
    output logic [CNT_W-1:0] ovf_count
);

    logic         s1_valid_q, s1_valid_d;
    logic         s1_sign_a_q, s1_sign_a_d;
    logic         s1_eff_sub_q, s1_eff_sub_d;
    logic         s1_eff_sign_b_q, s1_eff_sign_b_d;
    logic [W:0]   s1_sum_q, s1_sum_d;
    logic [W:0]   s1_diff_q, s1_diff_d;

    logic             out_valid_q, out_valid_d;
    logic             res_sign_q, res_sign_d;
    logic [W-1:0]     res_mag_q, res_mag_d;
    logic             o_carry_q, o_carry_d;
    logic             shift_q, shift_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic         s2_adv, s1_adv, accept;
    logic         r_sign, r_carry, r_shift, r_zero;
    logic [W-1:0] r_mag;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d      = s1_valid_q;
        s1_sign_a_d     = s1_sign_a_q;
        s1_eff_sub_d    = s1_eff_sub_q;
        s1_eff_sign_b_d = s1_eff_sign_b_q;
        s1_sum_d        = s1_sum_q;
        s1_diff_d       = s1_diff_q;
        if (accept) begin
            s1_valid_d      = 1'b1;
            s1_sign_a_d     = sign_a;
            s1_eff_sub_d    = sign_a ^ sign_b ^ sub;
            s1_eff_sign_b_d = sign_b ^ sub;
            s1_sum_d        = {1'b0, mag_a} + {1'b0, mag_b};
            s1_diff_d       = {1'b0, mag_a} - {1'b0, mag_b};
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // A borrow out of diff means |B| > |A|, so the result takes B's sign.
    always_comb begin
        r_mag   = '0;
        r_sign  = 1'b0;
        r_carry = 1'b0;
        r_shift = 1'b0;
        if (!s1_eff_sub_q) begin
            r_mag   = s1_sum_q[W-1:0];
            r_carry = s1_sum_q[W];
            r_sign  = s1_sign_a_q;
            r_shift = s1_sum_q[W];
`ifdef SIGNMAG_SAT_EN
            if (s1_sum_q[W]) begin
                r_mag   = '1;
                r_shift = 1'b0;
            end
`endif
        end else if (!s1_diff_q[W]) begin
            r_mag  = s1_diff_q[W-1:0];
            r_sign = s1_sign_a_q;
        end else begin
            r_mag  = -s1_diff_q[W-1:0];
            r_sign = s1_eff_sign_b_q;
        end
        r_zero = (r_mag == '0) && !r_carry;
        if (r_zero) begin
            r_sign = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        res_sign_d  = res_sign_q;
        res_mag_d   = res_mag_q;
        o_carry_d   = o_carry_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            res_sign_d  = r_sign;
            res_mag_d   = r_mag;
            o_carry_d   = r_carry;
            shift_d     = r_shift;
            zero_d      = r_zero;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (out_valid_q && out_ready && o_carry_q && !(&ovf_q)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_sign_a_q     <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
            s1_eff_sign_b_q <= 1'b0;
            s1_sum_q        <= '0;
            s1_diff_q       <= '0;
            out_valid_q     <= 1'b0;
            res_sign_q      <= 1'b0;
            res_mag_q       <= '0;
            o_carry_q       <= 1'b0;
            shift_q         <= 1'b0;
            zero_q          <= 1'b0;
            ovf_q           <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_sign_a_q     <= s1_sign_a_d;
            s1_eff_sub_q    <= s1_eff_sub_d;
            s1_eff_sign_b_q <= s1_eff_sign_b_d;
            s1_sum_q        <= s1_sum_d;
            s1_diff_q       <= s1_diff_d;
            out_valid_q     <= out_valid_d;
            res_sign_q      <= res_sign_d;
            res_mag_q       <= res_mag_d;
            o_carry_q       <= o_carry_d;
            shift_q         <= shift_d;
            zero_q          <= zero_d;
            ovf_q           <= ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign res_sign   = res_sign_q;
    assign res_mag    = res_mag_q;
    assign o_carry    = o_carry_q;
    assign shift_flag = shift_q;
    assign res_zero   = zero_q;
    assign ovf_count  = ovf_q;

endmodule

// File: tb/tb_signmag_addsub_pipe.sv
// Bench for signmag_addsub_pipe: signed-integer reference model plus
// directed spec cases, backpressure, mid-flight reset and counter saturation.
`timescale 1ns/1ps
module tb_signmag_addsub_pipe;

    localparam int W     = 24;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, sub, sign_a, sign_b;
    logic [W-1:0]     mag_a, mag_b;
    logic             out_valid, out_ready;
    logic             res_sign, o_carry, shift_flag, res_zero;
    logic [W-1:0]     res_mag;
    logic [CNT_W-1:0] ovf_count;

    int errors = 0;
    int checks = 0;

    signmag_addsub_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .sign_a(sign_a), .mag_a(mag_a),
        .sign_b(sign_b), .mag_b(mag_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_sign(res_sign), .res_mag(res_mag),
        .o_carry(o_carry), .shift_flag(shift_flag),
        .res_zero(res_zero), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mag;
        bit           sign;
        bit           carry;
        bit           shift;
        bit           zero;
        int           t;
    } item_t;

    item_t q[$];
    int    cyc   = 0;
    int    m_ovf = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: treat operands as signed integers and derive sign/magnitude.
    function automatic item_t model(input bit sa, input longint ma,
                                    input bit sb, input longint mb,
                                    input bit s);
        item_t  it;
        longint va, vb, r, a;
        va = sa ? -ma : ma;
        vb = (sb ^ s) ? -mb : mb;
        r  = va + vb;
        a  = (r < 0) ? -r : r;
        it.carry = (a >= (64'd1 << W));
        it.zero  = (a == 0);
        it.sign  = it.zero ? 1'b0 : (r < 0);
        it.mag   = a[W-1:0];
        it.shift = it.carry;
`ifdef SIGNMAG_SAT_EN
        if (it.carry) begin
            it.mag   = '1;
            it.shift = 1'b0;
        end
`endif
        it.t = 0;
        return it;
    endfunction

    always @(negedge clk) begin
        item_t it;
        #2;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_ovf_count", ovf_count, 0);
        end else begin
            chk("out_valid", out_valid,
                (q.size() > 0 && (cyc - q[0].t) >= 2) ? 1 : 0);
            chk("in_ready", in_ready, (q.size() < 2 || out_ready) ? 1 : 0);
            chk("ovf_count", ovf_count, m_ovf);
            if (out_valid && q.size() > 0) begin
                chk("res_mag", res_mag, q[0].mag);
                chk("res_sign", res_sign, q[0].sign);
                chk("o_carry", o_carry, q[0].carry);
                chk("shift_flag", shift_flag, q[0].shift);
                chk("res_zero", res_zero, q[0].zero);
                if (out_ready) begin
                    if (q[0].carry && m_ovf < (1 << CNT_W) - 1) m_ovf++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                it   = model(sign_a, mag_a, sign_b, mag_b, sub);
                it.t = cyc;
                q.push_back(it);
            end
        end
        cyc++;
    end

    task automatic set_op(input bit sa, input logic [W-1:0] ma,
                          input bit sb, input logic [W-1:0] mb, input bit s);
        sign_a = sa; mag_a = ma; sign_b = sb; mag_b = mb; sub = s;
    endtask

    task automatic lit(input string name,
                       input bit sa, input logic [W-1:0] ma,
                       input bit sb, input logic [W-1:0] mb, input bit s,
                       input logic [W-1:0] em, input bit es, input bit ec,
                       input bit esh, input bit ez);
        bit got;
        @(negedge clk);
        set_op(sa, ma, sb, mb, s);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            #3;
            if (out_valid) begin
                got = 1;
                chk({name, "_mag"}, res_mag, em);
                chk({name, "_sign"}, res_sign, es);
                chk({name, "_carry"}, o_carry, ec);
                chk({name, "_shift"}, shift_flag, esh);
                chk({name, "_zero"}, res_zero, ez);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rmag(input logic [W-1:0] other);
        logic [W-1:0] m;
        m = W'($urandom);
        case ($urandom_range(0, 3))
            0: m = W'($urandom);
            1: m = W'($urandom_range(0, 15));
            2: m = other;
            default: m[W-1] = 1'b1;
        endcase
        return m;
    endfunction

    logic [W-1:0] bp_mag [4];
    logic [W-1:0] ma_r;
    int           acc;
    bit           pend;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_op(0, '0, 0, '0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #3;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_ovf", ovf_count, 0);

`ifdef SIGNMAG_SAT_EN
        lit("ovf_add", 0, 24'h800000, 0, 24'h800000, 0, 24'hFFFFFF, 0, 1, 0, 0);
`else
        lit("ovf_add", 0, 24'h800000, 0, 24'h800000, 0, 24'h000000, 0, 1, 1, 0);
`endif
        #3;
        chk("ovf_count_1", ovf_count, 1);
        lit("p5_m3", 0, 24'd5, 1, 24'd3, 0, 24'd2, 0, 0, 0, 0);
        lit("m5_p3", 1, 24'd5, 0, 24'd3, 0, 24'd2, 1, 0, 0, 0);
        lit("p3_sub_p5", 0, 24'd3, 0, 24'd5, 1, 24'd2, 1, 0, 0, 0);
        lit("p7_m7", 0, 24'd7, 1, 24'd7, 0, 24'd0, 0, 0, 0, 1);
        lit("m0_m0", 1, 24'd0, 1, 24'd0, 0, 24'd0, 0, 0, 0, 1);
        lit("p0_m0", 0, 24'd0, 1, 24'd0, 0, 24'd0, 0, 0, 0, 1);

        // Backpressure: four beats offered while downstream is stalled.
        bp_mag[0] = 24'd11; bp_mag[1] = 24'd22;
        bp_mag[2] = 24'd33; bp_mag[3] = 24'd44;
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            set_op(0, bp_mag[acc], 1, 24'd1, 0);
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 2);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && acc < 4; i++) begin
            @(negedge clk);
            set_op(0, bp_mag[acc], 1, 24'd1, 0);
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
        end
        chk("bp_all_accepted", acc, 4);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while a result is stalled at the output with ovf_count=3.
        rst = 1'b1;
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        set_op(0, 24'h800000, 0, 24'h900000, 0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #3;
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_ovf", ovf_count, 3);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_ovf", ovf_count, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        set_op(1, 24'd9, 0, 24'd4, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        chk("lat_cycle1", out_valid, 0);
        @(negedge clk);
        #3;
        chk("lat_cycle2", out_valid, 1);
        chk("lat_mag", res_mag, 5);
        chk("lat_sign", res_sign, 1);

        // Random traffic with random backpressure.
        pend = 0;
        repeat (3000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                in_valid = ($urandom_range(0, 2) != 0);
                ma_r = W'($urandom);
                set_op($urandom_range(0, 1) == 1, ma_r,
                       $urandom_range(0, 1) == 1, rmag(ma_r),
                       $urandom_range(0, 1) == 1);
                mag_a = rmag(mag_b);
            end
            #1;
            pend = in_valid && !in_ready;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        // Counter saturation.
        set_op(0, 24'h800000, 0, 24'h800000, 0);
        in_valid = 1'b1;
        repeat (70000) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        chk("ovf_saturated", ovf_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
